// File: rtl/bcd_pkg.sv
// Shared definitions for the binary-to-BCD datapath: digit width, add-3 correction
// constants and the registered result record.
package bcd_pkg;

  localparam int BCD_DIGIT_W    = 4;
  localparam int ADD3_THRESHOLD = 5;
  localparam int ADD3_ADDEND    = 3;
  localparam int BCD_MAX_DIGIT  = 9;

  typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

  typedef struct packed {
    logic       inv;
    bcd_digit_t digit;
  } add3_result_t;

endpackage

// File: rtl/add_three_if.sv
// Digit-in / corrected-digit-out bundle of the add-3 cell. The master supplies {A,B,C,D}
// and observes {W,X,Y,Z} plus INV; the cell itself is the slave.
interface add_three_if;

  logic A, B, C, D;
  logic W, X, Y, Z;
  logic INV;

  modport master (output A, B, C, D, input W, X, Y, Z, INV);
  modport slave  (input A, B, C, D, output W, X, Y, Z, INV);

endinterface

// File: rtl/add3_core.sv
// Combinational add-3 correction: digits >= THRESHOLD get ADDEND added mod 16, and
// digits above 9 are flagged as not valid BCD. Also used unregistered by the converter.
module add3_core
  import bcd_pkg::*;
#(
  parameter int THRESHOLD = ADD3_THRESHOLD,
  parameter int ADDEND    = ADD3_ADDEND
) (
  input  bcd_digit_t digit_i,
  output bcd_digit_t digit_o,
  output logic       invalid_o
);

  localparam bcd_digit_t THRESHOLD_C = bcd_digit_t'(THRESHOLD);
  localparam bcd_digit_t ADDEND_C    = bcd_digit_t'(ADDEND);
  localparam bcd_digit_t MAX_DIGIT_C = bcd_digit_t'(BCD_MAX_DIGIT);

  // The 4-bit sum drops the carry on purpose, so 13..15 wrap to 0..2.
  assign digit_o   = (digit_i >= THRESHOLD_C) ? digit_i + ADDEND_C : digit_i;
  assign invalid_o = (digit_i > MAX_DIGIT_C);

endmodule

// File: rtl/add_three.sv
// Registered add-3 correction cell: one digit accepted per cycle, and the corrected
// digit plus its invalid flag appear one clock later, driven only from flops.
module add_three
  import bcd_pkg::*;
#(
  parameter int THRESHOLD = ADD3_THRESHOLD,
  parameter int ADDEND    = ADD3_ADDEND
) (
  input  logic         clk,
  input  logic         rst,
  add_three_if.slave   bus
);

  bcd_digit_t   digit_in;
  bcd_digit_t   corr_digit;
  logic         corr_inv;
  add3_result_t out_d;
  add3_result_t out_q;

  assign digit_in = {bus.A, bus.B, bus.C, bus.D};

  add3_core #(
    .THRESHOLD (THRESHOLD),
    .ADDEND    (ADDEND)
  ) u_core (
    .digit_i   (digit_in),
    .digit_o   (corr_digit),
    .invalid_o (corr_inv)
  );

  always_comb begin
    out_d       = '0;
    out_d.digit = corr_digit;
    out_d.inv   = corr_inv;
  end

  // NOTE: state uses non-blocking assignments; reset is synchronous, so it sits inside the clocked branch and overrides data.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign {bus.W, bus.X, bus.Y, bus.Z} = out_q.digit;
  assign bus.INV                      = out_q.inv;

endmodule

// File: tb/tb_add_three.sv
// Self-checking bench for add_three: directed scenarios plus a randomized stream
// compared against a plain-arithmetic reference of the add-3 rule.
module tb_add_three;
  import bcd_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  add_three_if bus ();

  add_three dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference: {INV, corrected digit} straight from the arithmetic definition.
  function automatic logic [4:0] model(input int v);
    int   r;
    logic inv;
    r   = (v >= 5) ? (v + 3) % 16 : v;
    inv = (v >= 10);
    return {inv, 4'(r)};
  endfunction

  function automatic logic [4:0] observed();
    return {bus.INV, bus.W, bus.X, bus.Y, bus.Z};
  endfunction

  task automatic set_inputs(input logic [3:0] v, input logic r);
    rst = r;
    {bus.A, bus.B, bus.C, bus.D} = v;
  endtask

  // Drive a digit, let one rising edge sample it, then settle before looking.
  task automatic apply(input logic [3:0] v, input logic r);
    set_inputs(v, r);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [4:0] obs;
    for (int i = 0; i < 2; i++) begin
      apply(4'b1001, 1'b1);
      obs = observed();
      tests_run++;
      if (obs !== 5'b0_0000) begin
        tests_failed++;
        $display("FAIL reset[%0d]: got %b expected %b", i, obs, 5'b0_0000);
      end
    end
  endtask

  task automatic test_sweep();
    logic [4:0] obs;
    logic [4:0] exp;
    for (int v = 0; v < 10; v++) begin
      apply(4'(v), 1'b0);
      obs = observed();
      exp = model(v);
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL sweep[%0d]: got %b expected %b", v, obs, exp);
      end
    end
  endtask

  task automatic test_threshold();
    logic [4:0] obs;
    apply(4'd4, 1'b0);
    obs = observed();
    tests_run++;
    if (obs !== 5'b0_0100) begin
      tests_failed++;
      $display("FAIL threshold_4: got %b expected %b", obs, 5'b0_0100);
    end
    apply(4'd5, 1'b0);
    obs = observed();
    tests_run++;
    if (obs !== 5'b0_1000) begin
      tests_failed++;
      $display("FAIL threshold_5: got %b expected %b", obs, 5'b0_1000);
    end
  endtask

  task automatic test_invalid();
    logic [3:0] ins  [4] = '{4'd10, 4'd12, 4'd13, 4'd15};
    logic [3:0] outs [4] = '{4'd13, 4'd15, 4'd0, 4'd2};
    logic [4:0] obs;
    for (int i = 0; i < 4; i++) begin
      apply(ins[i], 1'b0);
      obs = observed();
      tests_run++;
      if (obs !== {1'b1, outs[i]}) begin
        tests_failed++;
        $display("FAIL invalid[%0d]: got %b expected %b", ins[i], obs, {1'b1, outs[i]});
      end
    end
    apply(4'd3, 1'b0);
    obs = observed();
    tests_run++;
    if (obs !== 5'b0_0011) begin
      tests_failed++;
      $display("FAIL invalid_clear: got %b expected %b", obs, 5'b0_0011);
    end
  endtask

  task automatic test_mid_reset();
    logic       rsts [3] = '{1'b0, 1'b1, 1'b0};
    logic [4:0] exps [3] = '{5'b0_1010, 5'b0_0000, 5'b0_1010};
    logic [4:0] obs;
    for (int i = 0; i < 3; i++) begin
      apply(4'd7, rsts[i]);
      obs = observed();
      tests_run++;
      if (obs !== exps[i]) begin
        tests_failed++;
        $display("FAIL mid_reset[%0d]: got %b expected %b", i, obs, exps[i]);
      end
    end
  endtask

  // New digit every edge; also change the input right after the edge to prove
  // the outputs hold the previous result rather than following the input.
  task automatic test_latency();
    logic [3:0] cur;
    logic [3:0] nxt;
    logic       cur_rst;
    logic [4:0] exp;
    logic [4:0] obs;
    cur     = 4'($urandom_range(15));
    cur_rst = 1'b0;
    set_inputs(cur, cur_rst);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      exp = cur_rst ? 5'b0_0000 : model(int'(cur));
      obs = observed();
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL latency_edge[%0d] in=%0d rst=%b: got %b expected %b", i, cur, cur_rst, obs, exp);
      end
      nxt     = 4'($urandom_range(15));
      cur_rst = ($urandom_range(9) == 0);
      set_inputs(nxt, cur_rst);
      #2;
      obs = observed();
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL latency_hold[%0d] new_in=%0d: got %b expected %b", i, nxt, obs, exp);
      end
      cur = nxt;
    end
  endtask

  initial begin
    set_inputs(4'b1001, 1'b1);
    test_reset();
    test_sweep();
    test_threshold();
    test_invalid();
    test_mid_reset();
    test_latency();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
